// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multicycle MIPS main control FSM
// Moore decode per state; pcEn in BEQ/BNE also depends on the ALU zero flag.
module mips_multicycle_ctrl #(
  parameter bit ENABLE_BNE = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pcEn,
  output logic       IorD,
  output logic       memwrite,
  output logic       IRwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrcA,
  output logic [1:0] alusrcB,
  output logic [1:0] pcsrc,
  output logic [2:0] alucontrol,
  output logic [3:0] state,
  output logic       instr_done
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BEQ    = 4'd8,
    S_BNE    = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11,
    S_JUMP   = 4'd12
  } state_t;

  state_t r_state;
  state_t w_next;
  state_t w_dec;
  logic   w_illegal;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next    = S_FETCH;
    w_illegal = 1'b0;
    case (r_state)
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: begin
        case (op)
          6'b100011, 6'b101011: w_next = S_MEMADR;
          6'b000000:            w_next = S_EXEC;
          6'b000100:            w_next = S_BEQ;
          6'b000101: begin
            if (ENABLE_BNE) w_next = S_BNE;
            else            w_illegal = 1'b1;
          end
          6'b001000:            w_next = S_ADDIEX;
          6'b000010:            w_next = S_JUMP;
          default:              w_illegal = 1'b1;
        endcase
      end
      S_MEMADR: w_next = (op == 6'b100011) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  w_next = S_MEMWB;
      S_EXEC:   w_next = S_ALUWB;
      S_ADDIEX: w_next = S_ADDIWB;
      default:  w_next = S_FETCH;
    endcase
  end

  // While reset is high decode as FETCH, then mask every strobe below.
  assign w_dec = reset ? S_FETCH : r_state;

  always_comb begin
    pcEn       = 1'b0;
    IorD       = 1'b0;
    memwrite   = 1'b0;
    IRwrite    = 1'b0;
    regdst     = 1'b0;
    memtoreg   = 1'b0;
    regwrite   = 1'b0;
    alusrcA    = 1'b0;
    alusrcB    = 2'b00;
    pcsrc      = 2'b00;
    alucontrol = 3'b010;
    instr_done = 1'b0;
    case (w_dec)
      S_FETCH: begin
        alusrcB = 2'b01;
        IRwrite = 1'b1;
        pcEn    = 1'b1;
      end
      S_DECODE: begin
        alusrcB    = 2'b11;
        instr_done = w_illegal;
      end
      S_MEMADR: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
      end
      S_MEMRD: IorD = 1'b1;
      S_MEMWB: begin
        memtoreg   = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        memwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_EXEC: begin
        alusrcA = 1'b1;
        case (funct)
          6'b100010: alucontrol = 3'b110;
          6'b100100: alucontrol = 3'b000;
          6'b100101: alucontrol = 3'b001;
          6'b101010: alucontrol = 3'b111;
          default:   alucontrol = 3'b010;
        endcase
      end
      S_ALUWB: begin
        regdst     = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_BEQ, S_BNE: begin
        alusrcA    = 1'b1;
        alucontrol = 3'b110;
        pcsrc      = 2'b01;
        pcEn       = (w_dec == S_BEQ) ? zero : ~zero;
        instr_done = 1'b1;
      end
      S_ADDIEX: begin
        alusrcA = 1'b1;
        alusrcB = 2'b10;
      end
      S_ADDIWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      S_JUMP: begin
        pcsrc      = 2'b10;
        pcEn       = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    if (reset) begin
      pcEn       = 1'b0;
      memwrite   = 1'b0;
      IRwrite    = 1'b0;
      regwrite   = 1'b0;
      instr_done = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - table-driven bench for mips_multicycle_ctrl
// Control word bits: pcEn IorD memwrite IRwrite regdst memtoreg regwrite alusrcA alusrcB pcsrc alucontrol instr_done
module tb_mips_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;

  logic       a_pcEn, a_IorD, a_memwrite, a_IRwrite, a_regdst, a_memtoreg, a_regwrite, a_alusrcA, a_instr_done;
  logic [1:0] a_alusrcB, a_pcsrc;
  logic [2:0] a_alucontrol;
  logic [3:0] a_state;
  logic       b_pcEn, b_IorD, b_memwrite, b_IRwrite, b_regdst, b_memtoreg, b_regwrite, b_alusrcA, b_instr_done;
  logic [1:0] b_alusrcB, b_pcsrc;
  logic [2:0] b_alucontrol;
  logic [3:0] b_state;

  always #5 clk = ~clk;

  mips_multicycle_ctrl dut_a (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcEn(a_pcEn), .IorD(a_IorD), .memwrite(a_memwrite), .IRwrite(a_IRwrite),
    .regdst(a_regdst), .memtoreg(a_memtoreg), .regwrite(a_regwrite), .alusrcA(a_alusrcA),
    .alusrcB(a_alusrcB), .pcsrc(a_pcsrc), .alucontrol(a_alucontrol), .state(a_state),
    .instr_done(a_instr_done)
  );

  mips_multicycle_ctrl #(.ENABLE_BNE(1'b0)) dut_b (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pcEn(b_pcEn), .IorD(b_IorD), .memwrite(b_memwrite), .IRwrite(b_IRwrite),
    .regdst(b_regdst), .memtoreg(b_memtoreg), .regwrite(b_regwrite), .alusrcA(b_alusrcA),
    .alusrcB(b_alusrcB), .pcsrc(b_pcsrc), .alucontrol(b_alucontrol), .state(b_state),
    .instr_done(b_instr_done)
  );

  logic [15:0] w_ctl_a, w_ctl_b;
  assign w_ctl_a = {a_pcEn, a_IorD, a_memwrite, a_IRwrite, a_regdst, a_memtoreg, a_regwrite,
                    a_alusrcA, a_alusrcB, a_pcsrc, a_alucontrol, a_instr_done};
  assign w_ctl_b = {b_pcEn, b_IorD, b_memwrite, b_IRwrite, b_regdst, b_memtoreg, b_regwrite,
                    b_alusrcA, b_alusrcB, b_pcsrc, b_alucontrol, b_instr_done};

  localparam logic [15:0] C_RST  = 16'b0000_0000_0100_0100;
  localparam logic [15:0] C_F    = 16'b1001_0000_0100_0100;
  localparam logic [15:0] C_D    = 16'b0000_0000_1100_0100;
  localparam logic [15:0] C_DI   = 16'b0000_0000_1100_0101;
  localparam logic [15:0] C_MA   = 16'b0000_0001_1000_0100;
  localparam logic [15:0] C_MR   = 16'b0100_0000_0000_0100;
  localparam logic [15:0] C_MWB  = 16'b0000_0110_0000_0101;
  localparam logic [15:0] C_MWR  = 16'b0110_0000_0000_0101;
  localparam logic [15:0] C_EXS  = 16'b0000_0001_0000_1100;
  localparam logic [15:0] C_EXL  = 16'b0000_0001_0000_1110;
  localparam logic [15:0] C_EXA  = 16'b0000_0001_0000_0000;
  localparam logic [15:0] C_EXO  = 16'b0000_0001_0000_0010;
  localparam logic [15:0] C_AWB  = 16'b0000_1010_0000_0101;
  localparam logic [15:0] C_BRT  = 16'b1000_0001_0001_1101;
  localparam logic [15:0] C_BRN  = 16'b0000_0001_0001_1101;
  localparam logic [15:0] C_AEX  = 16'b0000_0001_1000_0100;
  localparam logic [15:0] C_AIWB = 16'b0000_0010_0000_0101;
  localparam logic [15:0] C_J    = 16'b1000_0000_0010_0101;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100;
  localparam logic [5:0] BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, ILL = 6'b111111;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  funct;
    logic        zero;
    logic [3:0]  st;
    logic [15:0] ctl;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(input logic [5:0] o, input logic [5:0] f, input logic z,
                              input logic [3:0] s, input logic [15:0] c);
    vec_t r;
    r.op = o; r.funct = f; r.zero = z; r.st = s; r.ctl = c;
    return r;
  endfunction

  task automatic run_vec(input vec_t t, input bit rst, input bit use_b, input string name);
    logic [3:0]  st;
    logic [15:0] ctl;
    logic [2:0]  strb;
    op = t.op; funct = t.funct; zero = t.zero; reset = rst;
    @(negedge clk);
    st   = use_b ? b_state : a_state;
    ctl  = use_b ? w_ctl_b : w_ctl_a;
    strb = {ctl[13], ctl[12], ctl[9]};
    checks++;
    if (st !== t.st) begin
      errors++;
      $display("FAIL %s state: got %0d expected %0d", name, st, t.st);
    end
    checks++;
    if (ctl !== t.ctl) begin
      errors++;
      $display("FAIL %s ctl (state %0d): got %b expected %b", name, st, ctl, t.ctl);
    end
    checks++;
    if (!$onehot0(strb)) begin
      errors++;
      $display("FAIL %s strobe exclusivity: got mem/IR/reg=%b expected at most one high", name, strb);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; op = 6'd0; funct = 6'd0; zero = 1'b0;

    tbl.push_back(mk(LW, 6'd0, 0, 4'd0, C_F));
    tbl.push_back(mk(LW, 6'd0, 0, 4'd1, C_D));
    tbl.push_back(mk(LW, 6'd0, 0, 4'd2, C_MA));
    tbl.push_back(mk(LW, 6'd0, 0, 4'd3, C_MR));
    tbl.push_back(mk(LW, 6'd0, 0, 4'd4, C_MWB));
    tbl.push_back(mk(RT, 6'b100010, 0, 4'd0, C_F));
    tbl.push_back(mk(RT, 6'b100010, 0, 4'd1, C_D));
    tbl.push_back(mk(RT, 6'b100010, 0, 4'd6, C_EXS));
    tbl.push_back(mk(RT, 6'b100010, 0, 4'd7, C_AWB));
    tbl.push_back(mk(RT, 6'b101010, 0, 4'd0, C_F));
    tbl.push_back(mk(RT, 6'b101010, 0, 4'd1, C_D));
    tbl.push_back(mk(RT, 6'b101010, 0, 4'd6, C_EXL));
    tbl.push_back(mk(RT, 6'b101010, 0, 4'd7, C_AWB));
    tbl.push_back(mk(RT, 6'b100100, 0, 4'd0, C_F));
    tbl.push_back(mk(RT, 6'b100100, 0, 4'd1, C_D));
    tbl.push_back(mk(RT, 6'b100100, 0, 4'd6, C_EXA));
    tbl.push_back(mk(RT, 6'b100100, 0, 4'd7, C_AWB));
    tbl.push_back(mk(RT, 6'b100101, 0, 4'd0, C_F));
    tbl.push_back(mk(RT, 6'b100101, 0, 4'd1, C_D));
    tbl.push_back(mk(RT, 6'b100101, 0, 4'd6, C_EXO));
    tbl.push_back(mk(RT, 6'b100101, 0, 4'd7, C_AWB));
    tbl.push_back(mk(BEQ, 6'd0, 1, 4'd0, C_F));
    tbl.push_back(mk(BEQ, 6'd0, 1, 4'd1, C_D));
    tbl.push_back(mk(BEQ, 6'd0, 1, 4'd8, C_BRT));
    tbl.push_back(mk(BEQ, 6'd0, 0, 4'd0, C_F));
    tbl.push_back(mk(BEQ, 6'd0, 0, 4'd1, C_D));
    tbl.push_back(mk(BEQ, 6'd0, 0, 4'd8, C_BRN));
    tbl.push_back(mk(BNE, 6'd0, 0, 4'd0, C_F));
    tbl.push_back(mk(BNE, 6'd0, 0, 4'd1, C_D));
    tbl.push_back(mk(BNE, 6'd0, 0, 4'd9, C_BRT));
    tbl.push_back(mk(BNE, 6'd0, 1, 4'd0, C_F));
    tbl.push_back(mk(BNE, 6'd0, 1, 4'd1, C_D));
    tbl.push_back(mk(BNE, 6'd0, 1, 4'd9, C_BRN));
    tbl.push_back(mk(SW, 6'd0, 0, 4'd0, C_F));
    tbl.push_back(mk(SW, 6'd0, 0, 4'd1, C_D));
    tbl.push_back(mk(SW, 6'd0, 0, 4'd2, C_MA));
    tbl.push_back(mk(SW, 6'd0, 0, 4'd5, C_MWR));
    tbl.push_back(mk(J, 6'd0, 0, 4'd0, C_F));
    tbl.push_back(mk(J, 6'd0, 0, 4'd1, C_D));
    tbl.push_back(mk(J, 6'd0, 0, 4'd12, C_J));
    tbl.push_back(mk(ADDI, 6'd0, 0, 4'd0, C_F));
    tbl.push_back(mk(ADDI, 6'd0, 0, 4'd1, C_D));
    tbl.push_back(mk(ADDI, 6'd0, 0, 4'd10, C_AEX));
    tbl.push_back(mk(ADDI, 6'd0, 0, 4'd11, C_AIWB));
    tbl.push_back(mk(ILL, 6'd0, 0, 4'd0, C_F));
    tbl.push_back(mk(ILL, 6'd0, 0, 4'd1, C_DI));
    tbl.push_back(mk(ILL, 6'd0, 0, 4'd0, C_F));

    @(posedge clk);
    #1;
    run_vec(mk(LW, 6'd0, 0, 4'd0, C_RST), 1'b1, 1'b0, "reset_state");

    foreach (tbl[i]) run_vec(tbl[i], 1'b0, 1'b0, $sformatf("vec%0d", i));

    // Reset arriving in the MEMWB cycle of lw must suppress the register write.
    run_vec(mk(LW, 6'd0, 0, 4'd1, C_D), 1'b0, 1'b0, "lw_rst_dec");
    run_vec(mk(LW, 6'd0, 0, 4'd2, C_MA), 1'b0, 1'b0, "lw_rst_madr");
    run_vec(mk(LW, 6'd0, 0, 4'd3, C_MR), 1'b0, 1'b0, "lw_rst_mrd");
    run_vec(mk(LW, 6'd0, 0, 4'd4, C_RST), 1'b1, 1'b0, "lw_rst_mwb");
    run_vec(mk(ADDI, 6'd0, 0, 4'd0, C_F), 1'b0, 1'b0, "addi_post_rst_f");
    run_vec(mk(ADDI, 6'd0, 0, 4'd1, C_D), 1'b0, 1'b0, "addi_post_rst_d");
    run_vec(mk(ADDI, 6'd0, 0, 4'd10, C_AEX), 1'b0, 1'b0, "addi_post_rst_ex");
    run_vec(mk(ADDI, 6'd0, 0, 4'd11, C_AIWB), 1'b0, 1'b0, "addi_post_rst_wb");

    // Instance with bne disabled treats op 000101 as illegal.
    run_vec(mk(BNE, 6'd0, 0, 4'd0, C_RST), 1'b1, 1'b1, "nobne_rst");
    run_vec(mk(BNE, 6'd0, 0, 4'd0, C_F), 1'b0, 1'b1, "nobne_f");
    run_vec(mk(BNE, 6'd0, 0, 4'd1, C_DI), 1'b0, 1'b1, "nobne_d");
    run_vec(mk(BNE, 6'd0, 0, 4'd0, C_F), 1'b0, 1'b1, "nobne_f2");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
